ct_rtu_entry_ptr_ctrl_96: RTL and testbench
===========================================

CT_RTU_ENTRY_PTR_CTRL_96 -- requirements
Module: ct_rtu_entry_ptr_ctrl_96

Interface
REQ-001 The block SHALL have no parameters; entry count is fixed at 96, binary index width at 7.
REQ-002 forever_cpuclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 cpurst  input  1  reset; synchronous and active-high.
REQ-004 x_create_vld  input  1  requester wants one entry allocated this cycle.
REQ-005 x_retire_vld  input  1  oldest entry is released this cycle.
REQ-006 x_flush  input  1  discard all allocated entries.
REQ-007 x_create_rdy  output  1  an entry is available for allocation.
REQ-008 x_create_ptr_expand  output  96  one-hot index of the next entry to allocate.
REQ-009 x_create_ptr  output  7  binary encoding of x_create_ptr_expand.
REQ-010 x_retire_ptr_expand  output  96  one-hot index of the oldest allocated entry.
REQ-011 x_retire_ptr  output  7  binary encoding of x_retire_ptr_expand.
REQ-012 x_entry_cnt  output  7  number of allocated entries, 0..96.
REQ-013 x_empty  output  1  x_entry_cnt == 0.
REQ-014 x_full  output  1  x_entry_cnt == 96.

Function
REQ-015 State SHALL be: create pointer (96-bit one-hot), retire pointer (96-bit one-hot), entry count (7-bit).
REQ-016 x_create_rdy SHALL equal !x_full, derived from registered count only, with no combinational path from any input.
REQ-017 A create SHALL be accepted iff x_create_vld & x_create_rdy & !x_flush.
REQ-018 A retire SHALL be accepted iff x_retire_vld & !x_empty & !x_flush; a retire at empty SHALL be ignored, with no state change.
REQ-019 Accepted create SHALL rotate the create pointer left by one bit next cycle, wrapping bit 95 to bit 0.
REQ-020 Accepted retire SHALL rotate the retire pointer left by one bit next cycle, wrapping bit 95 to bit 0.
REQ-021 Count update: create only +1; retire only -1; both accepted unchanged; neither unchanged.
REQ-022 Create and retire SHALL be independent in the same cycle, including when both pointers address the same entry.
REQ-023 At full with create and retire both valid: the create SHALL be rejected and the retire accepted, giving count 95 next cycle.
REQ-024 At empty with create and retire both valid: the create SHALL be accepted and the retire ignored, giving count 1 next cycle.
REQ-025 x_flush SHALL have priority over create/retire: next cycle count = 0, create pointer = current retire pointer, retire pointer unchanged.
REQ-026 The binary outputs SHALL be combinational one-hot-to-binary encodings of the registered one-hot pointers, with zero latency (bit k -> value k).
REQ-027 Both one-hot pointers SHALL hold exactly one set bit in every cycle after reset.
REQ-028 Count SHALL never exceed 96 or underflow below 0.
REQ-029 x_create_ptr_expand SHALL equal x_retire_ptr_expand whenever count is 0 or 96.

Reset
REQ-030 When cpurst is high at a clock edge, next-cycle state SHALL be: create pointer = 96'h1, retire pointer = 96'h1, count = 0.
REQ-031 Reset SHALL override flush, create and retire in the same cycle.
REQ-032 Output values after reset SHALL be: x_create_ptr = 0, x_retire_ptr = 0, x_entry_cnt = 0, x_empty = 1, x_full = 0, x_create_rdy = 1.
REQ-033 Reset asserted mid-operation SHALL restore the REQ-030 state regardless of prior contents.

Verification
REQ-034 Bench SHALL cover: reset, then 96 consecutive creates -> x_create_ptr steps 0..95 and wraps to 0, count 96, x_full = 1, x_create_rdy = 0.
REQ-035 Bench SHALL cover: full, then create + retire in one cycle -> count 95, x_retire_ptr = 1, x_create_ptr unchanged (0).
REQ-036 Bench SHALL cover: empty, then create + retire in one cycle -> count 1, x_create_ptr +1, x_retire_ptr unchanged.
REQ-037 Bench SHALL cover: 10 creates, 4 retires, then flush asserted together with create -> count 0, x_create_ptr = 4, x_retire_ptr = 4, x_empty = 1.
REQ-038 Bench SHALL cover: 50 creates, then cpurst high for one cycle while create is valid -> all outputs at REQ-032 values.
REQ-039 Bench SHALL cover: random create/retire/flush for 10k cycles, checked against a reference model -> exactly one bit set in each pointer, binary output equal to one-hot position, count in 0..96 and equal to (create - retire) mod 96 (96 when full).

Source files
------------

// File: rtl/ct_rtu_entry_ptr_ctrl_96_if.sv
// rtl/ct_rtu_entry_ptr_ctrl_96_if.sv - create/retire/flush handshake and pointer outputs of the 96-entry pointer controller
interface ct_rtu_entry_ptr_ctrl_96_if;
    logic        x_create_vld;
    logic        x_retire_vld;
    logic        x_flush;
    logic        x_create_rdy;
    logic [95:0] x_create_ptr_expand;
    logic [6:0]  x_create_ptr;
    logic [95:0] x_retire_ptr_expand;
    logic [6:0]  x_retire_ptr;
    logic [6:0]  x_entry_cnt;
    logic        x_empty;
    logic        x_full;

    modport master (
        output x_create_vld,
        output x_retire_vld,
        output x_flush,
        input  x_create_rdy,
        input  x_create_ptr_expand,
        input  x_create_ptr,
        input  x_retire_ptr_expand,
        input  x_retire_ptr,
        input  x_entry_cnt,
        input  x_empty,
        input  x_full
    );

    modport slave (
        input  x_create_vld,
        input  x_retire_vld,
        input  x_flush,
        output x_create_rdy,
        output x_create_ptr_expand,
        output x_create_ptr,
        output x_retire_ptr_expand,
        output x_retire_ptr,
        output x_entry_cnt,
        output x_empty,
        output x_full
    );
endinterface

// File: rtl/ct_rtu_entry_ptr_ctrl_96.sv
// rtl/ct_rtu_entry_ptr_ctrl_96.sv - one-hot create/retire pointer ring with entry count for a 96-entry queue
module ct_rtu_entry_ptr_ctrl_96 (
    input  logic                           forever_cpuclk,
    input  logic                           cpurst,
    ct_rtu_entry_ptr_ctrl_96_if.slave      bus
);
    localparam logic [6:0] ENTRY_MAX = 7'd96;

    logic [95:0] create_ptr_q;
    logic [95:0] retire_ptr_q;
    logic [6:0]  entry_cnt_q;

    logic [95:0] create_ptr_d;
    logic [95:0] retire_ptr_d;
    logic [6:0]  entry_cnt_d;

    logic        empty;
    logic        full;
    logic        create_acc;
    logic        retire_acc;

    function automatic logic [6:0] onehot_to_bin(input logic [95:0] v);
        logic [6:0] b;
        b = 7'd0;
        for (int k = 0; k < 96; k++) begin
            if (v[k]) begin
                b = b | 7'(k);
            end
        end
        return b;
    endfunction

    // status comes from registered count only, so create_rdy has no input path
    assign empty      = (entry_cnt_q == 7'd0);
    assign full       = (entry_cnt_q == ENTRY_MAX);
    assign create_acc = bus.x_create_vld & ~full  & ~bus.x_flush;
    assign retire_acc = bus.x_retire_vld & ~empty & ~bus.x_flush;

    always_comb begin
        create_ptr_d = create_ptr_q;
        retire_ptr_d = retire_ptr_q;
        entry_cnt_d  = entry_cnt_q;
        if (bus.x_flush) begin
            // flush rewinds allocation to the oldest live slot
            create_ptr_d = retire_ptr_q;
            entry_cnt_d  = 7'd0;
        end else begin
            if (create_acc) begin
                create_ptr_d = {create_ptr_q[94:0], create_ptr_q[95]};
            end
            if (retire_acc) begin
                retire_ptr_d = {retire_ptr_q[94:0], retire_ptr_q[95]};
            end
            case ({create_acc, retire_acc})
                2'b10:   entry_cnt_d = entry_cnt_q + 7'd1;
                2'b01:   entry_cnt_d = entry_cnt_q - 7'd1;
                default: entry_cnt_d = entry_cnt_q;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            create_ptr_q <= 96'h1;
            retire_ptr_q <= 96'h1;
            entry_cnt_q  <= 7'd0;
        end else begin
            create_ptr_q <= create_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            entry_cnt_q  <= entry_cnt_d;
        end
    end

    assign bus.x_create_rdy        = ~full;
    assign bus.x_create_ptr_expand = create_ptr_q;
    assign bus.x_retire_ptr_expand = retire_ptr_q;
    assign bus.x_create_ptr        = onehot_to_bin(create_ptr_q);
    assign bus.x_retire_ptr        = onehot_to_bin(retire_ptr_q);
    assign bus.x_entry_cnt         = entry_cnt_q;
    assign bus.x_empty             = empty;
    assign bus.x_full              = full;
endmodule

// File: tb/tb_ct_rtu_entry_ptr_ctrl_96.sv
// tb/tb_ct_rtu_entry_ptr_ctrl_96.sv - scoreboard bench for the 96-entry pointer controller
module tb_ct_rtu_entry_ptr_ctrl_96;
    logic clk;
    logic rst;

    ct_rtu_entry_ptr_ctrl_96_if bus();

    ct_rtu_entry_ptr_ctrl_96 dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cidx;
        int ridx;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // reference model: plain integer indices and an occupancy count
    int m_ci  = 0;
    int m_ri  = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_pos(input logic [95:0] v);
        int p;
        p = -1;
        for (int k = 0; k < 96; k++) begin
            if (v[k]) p = k;
        end
        return p;
    endfunction

    task automatic step(input logic r, input logic cv, input logic rv, input logic fl);
        exp_t e;
        bit ca;
        bit ra;
        @(negedge clk);
        rst              = r;
        bus.x_create_vld = cv;
        bus.x_retire_vld = rv;
        bus.x_flush      = fl;
        if (r) begin
            m_ci = 0; m_ri = 0; m_cnt = 0;
        end else if (fl) begin
            m_ci = m_ri; m_cnt = 0;
        end else begin
            ca = cv && (m_cnt < 96);
            ra = rv && (m_cnt > 0);
            if (ca) m_ci = (m_ci + 1) % 96;
            if (ra) m_ri = (m_ri + 1) % 96;
            m_cnt = m_cnt + int'(ca) - int'(ra);
        end
        e.cidx = m_ci;
        e.ridx = m_ri;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitor: every post-edge sample is a DUT response; compare against queued expectation
    initial begin
        exp_t e;
        logic [95:0] one;
        one = 96'h1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("create_ptr",        96'(bus.x_create_ptr), 96'(e.cidx));
                chk("retire_ptr",        96'(bus.x_retire_ptr), 96'(e.ridx));
                chk("create_ptr_expand", bus.x_create_ptr_expand, one << e.cidx);
                chk("retire_ptr_expand", bus.x_retire_ptr_expand, one << e.ridx);
                chk("entry_cnt",         96'(bus.x_entry_cnt), 96'(e.cnt));
                chk("empty",             96'(bus.x_empty), 96'(e.cnt == 0));
                chk("full",              96'(bus.x_full), 96'(e.cnt == 96));
                chk("create_rdy",        96'(bus.x_create_rdy), 96'(e.cnt != 96));
                chk("create_onehot",     96'($countones(bus.x_create_ptr_expand)), 96'd1);
                chk("retire_onehot",     96'($countones(bus.x_retire_ptr_expand)), 96'd1);
                chk("create_bin_pos",    96'(bus.x_create_ptr), 96'(onehot_pos(bus.x_create_ptr_expand)));
                chk("retire_bin_pos",    96'(bus.x_retire_ptr), 96'(onehot_pos(bus.x_retire_ptr_expand)));
                chk("cnt_vs_ptr_dist",   96'(bus.x_entry_cnt),
                    96'(((bus.x_entry_cnt == 7'd96) ? 96 :
                         ((int'(bus.x_create_ptr) - int'(bus.x_retire_ptr) + 96) % 96))));
            end
        end
    end

    initial begin
        int phase_cv;
        int phase_rv;
        int guard;
        rst              = 1'b1;
        bus.x_create_vld = 1'b0;
        bus.x_retire_vld = 1'b0;
        bus.x_flush      = 1'b0;

        // reset values
        step(1, 0, 0, 0);
        settle();
        chk("rst_create_ptr", 96'(bus.x_create_ptr), 96'd0);
        chk("rst_retire_ptr", 96'(bus.x_retire_ptr), 96'd0);
        chk("rst_cnt",        96'(bus.x_entry_cnt), 96'd0);
        chk("rst_empty",      96'(bus.x_empty), 96'd1);
        chk("rst_full",       96'(bus.x_full), 96'd0);
        chk("rst_rdy",        96'(bus.x_create_rdy), 96'd1);

        // fill to full, create pointer wraps back to 0
        for (int i = 0; i < 96; i++) begin
            step(0, 1, 0, 0);
            settle();
            chk("fill_create_ptr", 96'(bus.x_create_ptr), 96'((i + 1) % 96));
        end
        chk("full_cnt",  96'(bus.x_entry_cnt), 96'd96);
        chk("full_flag", 96'(bus.x_full), 96'd1);
        chk("full_rdy",  96'(bus.x_create_rdy), 96'd0);
        chk("full_ptr_eq", bus.x_create_ptr_expand, bus.x_retire_ptr_expand);

        // create + retire at full: only retire accepted
        step(0, 1, 1, 0);
        settle();
        chk("fullcr_cnt",  96'(bus.x_entry_cnt), 96'd95);
        chk("fullcr_rptr", 96'(bus.x_retire_ptr), 96'd1);
        chk("fullcr_cptr", 96'(bus.x_create_ptr), 96'd0);

        // drain to empty, retire at empty ignored
        for (int i = 0; i < 95; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        settle();
        chk("drain_empty", 96'(bus.x_empty), 96'd1);
        chk("drain_rptr",  96'(bus.x_retire_ptr), 96'd0);

        // create + retire at empty: only create accepted
        step(0, 1, 1, 0);
        settle();
        chk("emptycr_cnt",  96'(bus.x_entry_cnt), 96'd1);
        chk("emptycr_cptr", 96'(bus.x_create_ptr), 96'd1);
        chk("emptycr_rptr", 96'(bus.x_retire_ptr), 96'd0);

        // flush with create: pointers meet at the retire pointer
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++)  step(0, 0, 1, 0);
        step(0, 1, 0, 1);
        settle();
        chk("flush_cnt",   96'(bus.x_entry_cnt), 96'd0);
        chk("flush_cptr",  96'(bus.x_create_ptr), 96'd4);
        chk("flush_rptr",  96'(bus.x_retire_ptr), 96'd4);
        chk("flush_empty", 96'(bus.x_empty), 96'd1);

        // reset mid-operation overrides a valid create
        for (int i = 0; i < 50; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        settle();
        chk("midrst_cptr",  96'(bus.x_create_ptr), 96'd0);
        chk("midrst_rptr",  96'(bus.x_retire_ptr), 96'd0);
        chk("midrst_cnt",   96'(bus.x_entry_cnt), 96'd0);
        chk("midrst_empty", 96'(bus.x_empty), 96'd1);
        chk("midrst_full",  96'(bus.x_full), 96'd0);
        chk("midrst_rdy",   96'(bus.x_create_rdy), 96'd1);

        // random traffic with alternating fill/drain bias so both ends are reached
        phase_cv = 80;
        phase_rv = 30;
        for (int i = 0; i < 10000; i++) begin
            if (i % 300 == 0) begin
                phase_cv = (phase_cv == 80) ? 30 : 80;
                phase_rv = (phase_rv == 30) ? 80 : 30;
            end
            step(0,
                 ($urandom_range(99) < 32'(phase_cv)),
                 ($urandom_range(99) < 32'(phase_rv)),
                 ($urandom_range(199) == 0));
        end
        step(0, 0, 0, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
